demux_stream_nch: RTL and testbench



---
 rtl/demux_stream_nch.sv | 116 +++++++++++
 tb/tb_demux_stream_nch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_nch.sv
// demux_stream_nch
//
// Registered, flow-controlled 1-to-NUM_CH stream demultiplexer. Each beat
// from a single producer goes to the channel picked by in_sel. Every
// channel has its own one-beat holding register with a valid/ready
// handshake, so a stalled consumer blocks only beats addressed to it.
// Beats whose select is out of range are accepted, thrown away and
// counted in a saturating drop counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a beat
//   in_ready   beat is accepted this cycle (combinational, 0 in reset)
//   in_data    beat payload, BUS_WIDTH bits
//   in_sel     destination channel index, SEL_W bits
//   out_valid  per-channel: holding register is full
//   out_ready  per-channel: consumer takes the beat this cycle
//   out_data   flattened payloads, channel k at [k*BUS_WIDTH +: BUS_WIDTH]
//   drop_cnt   saturating count of beats accepted with out-of-range in_sel
module demux_stream_nch #(
   parameter  int BUS_WIDTH = 8,
   parameter  int NUM_CH    = 4,
   parameter  int CNT_WIDTH = 8,
   localparam int SEL_W     = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [BUS_WIDTH-1:0]        in_data,
   input  logic [SEL_W-1:0]            in_sel,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready,
   output logic [NUM_CH*BUS_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]        drop_cnt
);

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   logic [NUM_CH-1:0]    sel_oh;
   logic                 sel_ok;
   logic                 ch_free;
   logic                 accept;
   logic [NUM_CH-1:0]    load;

   logic [BUS_WIDTH-1:0] data_p0 [NUM_CH];
   logic [NUM_CH-1:0]    vld_p0;
   logic [CNT_WIDTH-1:0] drop_cnt_p0;

   // Input side: decode the select and work out whether the addressed
   // channel can take a beat. Decoding into a one-hot vector keeps an
   // out-of-range select from ever indexing past the channel arrays.
   always_comb begin
      sel_oh = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_oh[k] = 1'b1;
         end
      end
   end

   assign sel_ok  = |sel_oh;
   // A channel is free when empty or when its current beat leaves this edge.
   assign ch_free = |(sel_oh & (~vld_p0 | out_ready));
   assign in_ready = rst_n && (sel_ok ? ch_free : 1'b1);
   assign accept   = in_valid && in_ready;
   assign load     = sel_oh & {NUM_CH{accept}};

   // Stage p0: per-channel holding registers. A load on the same edge as a
   // drain wins, so the channel stays valid and throughput is one beat per
   // cycle per channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            data_p0[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (load[k]) begin
               data_p0[k] <= in_data;
               vld_p0[k]  <= 1'b1;
            end else if (out_ready[k]) begin
               vld_p0[k]  <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_p0 <= '0;
      end else if (accept && !sel_ok) begin
         drop_cnt_p0 <= sat_inc(drop_cnt_p0);
      end
   end

   // Output side: everything except in_ready comes straight from registers.
   assign out_valid = vld_p0;
   assign drop_cnt  = drop_cnt_p0;

   always_comb begin
      out_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         out_data[k*BUS_WIDTH +: BUS_WIDTH] = data_p0[k];
      end
   end

endmodule

// File: tb/tb_demux_stream_nch.sv
module tb_demux_stream_nch;

   logic        clk;
   logic        rst_n;

   // Instance A: default 4 channels, 8-bit data, 8-bit drop counter
   logic        a_in_valid;
   logic        a_in_ready;
   logic [7:0]  a_in_data;
   logic [1:0]  a_in_sel;
   logic [3:0]  a_out_valid;
   logic [3:0]  a_out_ready;
   logic [31:0] a_out_data;
   logic [7:0]  a_drop_cnt;

   // Instance B: 3 channels so select value 3 is out of range, 2-bit counter
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_data;
   logic [1:0]  b_in_sel;
   logic [2:0]  b_out_valid;
   logic [2:0]  b_out_ready;
   logic [23:0] b_out_data;
   logic [1:0]  b_drop_cnt;

   int checks;
   int errors;

   demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(4), .CNT_WIDTH(8)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_sel    (a_in_sel),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .drop_cnt  (a_drop_cnt)
   );

   demux_stream_nch #(.BUS_WIDTH(8), .NUM_CH(3), .CNT_WIDTH(2)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_sel    (b_in_sel),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .drop_cnt  (b_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b1;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd0;
      a_in_data   = 8'h99;
      a_out_ready = 4'h0;
      b_in_valid  = 1'b1;
      b_in_sel    = 2'd3;
      b_in_data   = 8'h98;
      b_out_ready = 3'h0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", a_out_valid); end
      checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", a_out_data); end
      checks++; if (a_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", a_drop_cnt); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_a: got %b expected 0", a_in_ready); end
      checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_b: got %b expected 0", b_in_ready); end
      tick();
      // A clock edge while held in reset must not load or count anything.
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL reset_edge_valid: got %b expected 0000", a_out_valid); end
      checks++; if (b_drop_cnt !== 2'd0) begin errors++; $display("FAIL reset_edge_drop: got %0d expected 0", b_drop_cnt); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_edge_in_ready: got %b expected 0", a_in_ready); end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      #3 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_route();
      logic [7:0] vals [4];
      logic [3:0] exp_v;
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      a_out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         a_in_valid = 1'b1;
         a_in_sel   = 2'(i);
         a_in_data  = vals[i];
         #1;
         checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready[%0d]: got %b expected 1", i, a_in_ready); end
         tick();
         exp_v = 4'b0001 << i;
         checks++; if (a_out_valid !== exp_v) begin errors++; $display("FAIL route_out_valid[%0d]: got %b expected %b", i, a_out_valid, exp_v); end
         checks++; if (a_out_data[i*8 +: 8] !== vals[i]) begin errors++; $display("FAIL route_out_data[%0d]: got %h expected %h", i, a_out_data[i*8 +: 8], vals[i]); end
      end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL route_drained: got %b expected 0000", a_out_valid); end
      checks++; if (a_drop_cnt !== 8'd0) begin errors++; $display("FAIL route_drop_cnt: got %0d expected 0", a_drop_cnt); end
   endtask

   task automatic test_backpressure();
      a_out_ready = 4'b1011;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd2;
      a_in_data   = 8'hA0;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a0: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL bp_valid_a0: got %b expected 0100", a_out_valid); end
      a_in_data = 8'hA1;
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_block_a1: got %b expected 0", a_in_ready); end
      tick();
      checks++; if (a_out_data[23:16] !== 8'hA0) begin errors++; $display("FAIL bp_hold_a0: got %h expected a0", a_out_data[23:16]); end
      checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL bp_hold_valid: got %b expected 0100", a_out_valid); end
      a_in_sel  = 2'd1;
      a_in_data = 8'hB0;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 4'b0110) begin errors++; $display("FAIL bp_b0_valid: got %b expected 0110", a_out_valid); end
      checks++; if (a_out_data[15:8] !== 8'hB0) begin errors++; $display("FAIL bp_b0_data: got %h expected b0", a_out_data[15:8]); end
      checks++; if (a_out_data[23:16] !== 8'hA0) begin errors++; $display("FAIL bp_a0_still: got %h expected a0", a_out_data[23:16]); end
      a_in_sel  = 2'd2;
      a_in_data = 8'hA1;
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_a1_blocked_again: got %b expected 0", a_in_ready); end
      // Consumer 2 takes A0; A1 goes in on the same edge.
      a_out_ready = 4'hF;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 4'b0100) begin errors++; $display("FAIL bp_a1_valid: got %b expected 0100", a_out_valid); end
      checks++; if (a_out_data[23:16] !== 8'hA1) begin errors++; $display("FAIL bp_a1_data: got %h expected a1", a_out_data[23:16]); end
      a_in_valid = 1'b0;
      tick();
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL bp_empty: got %b expected 0000", a_out_valid); end
   endtask

   task automatic test_reload();
      a_out_ready = 4'h0;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd0;
      a_in_data   = 8'h55;
      tick();
      checks++; if (a_out_data[7:0] !== 8'h55) begin errors++; $display("FAIL reload_first: got %h expected 55", a_out_data[7:0]); end
      a_out_ready = 4'b0001;
      a_in_data   = 8'h66;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b expected 1", a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 4'b0001) begin errors++; $display("FAIL reload_valid: got %b expected 0001", a_out_valid); end
      checks++; if (a_out_data[7:0] !== 8'h66) begin errors++; $display("FAIL reload_data: got %h expected 66", a_out_data[7:0]); end
      a_in_valid  = 1'b0;
      a_out_ready = 4'hF;
      tick();
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL reload_drained: got %b expected 0000", a_out_valid); end
   endtask

   task automatic test_drop();
      logic [1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      b_out_ready = 3'b111;
      for (int i = 0; i < 5; i++) begin
         b_in_valid = 1'b1;
         b_in_sel   = 2'd3;
         b_in_data  = 8'(8'hD0 + i);
         #1;
         checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready[%0d]: got %b expected 1", i, b_in_ready); end
         tick();
         checks++; if (b_drop_cnt !== exp_cnt[i]) begin errors++; $display("FAIL drop_cnt[%0d]: got %0d expected %0d", i, b_drop_cnt, exp_cnt[i]); end
         checks++; if (b_out_valid !== 3'b000) begin errors++; $display("FAIL drop_no_valid[%0d]: got %b expected 000", i, b_out_valid); end
      end
      b_in_sel  = 2'd2;
      b_in_data = 8'h5A;
      tick();
      checks++; if (b_out_valid !== 3'b100) begin errors++; $display("FAIL drop_inrange_valid: got %b expected 100", b_out_valid); end
      checks++; if (b_out_data[23:16] !== 8'h5A) begin errors++; $display("FAIL drop_inrange_data: got %h expected 5a", b_out_data[23:16]); end
      checks++; if (b_drop_cnt !== 2'd3) begin errors++; $display("FAIL drop_inrange_cnt: got %0d expected 3", b_drop_cnt); end
      b_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      a_out_ready = 4'b0101;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd1;
      a_in_data   = 8'hC1;
      tick();
      a_in_sel  = 2'd3;
      a_in_data = 8'hC3;
      tick();
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 4'b1010) begin errors++; $display("FAIL ar_stalled: got %b expected 1010", a_out_valid); end
      a_in_valid = 1'b1;
      a_in_sel   = 2'd0;
      a_in_data  = 8'hEE;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL ar_valid: got %b expected 0000", a_out_valid); end
      checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL ar_data: got %h expected 00000000", a_out_data); end
      checks++; if (b_drop_cnt !== 2'd0) begin errors++; $display("FAIL ar_drop_cnt: got %0d expected 0", b_drop_cnt); end
      checks++; if (b_out_valid !== 3'b000) begin errors++; $display("FAIL ar_b_valid: got %b expected 000", b_out_valid); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready: got %b expected 0", a_in_ready); end
      tick();
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready_edge: got %b expected 0", a_in_ready); end
      checks++; if (a_out_valid !== 4'b0000) begin errors++; $display("FAIL ar_valid_edge: got %b expected 0000", a_out_valid); end
      #3 rst_n = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL ar_release_ready: got %b expected 1", a_in_ready); end
      a_out_ready = 4'hF;
      a_in_sel    = 2'd3;
      a_in_data   = 8'h77;
      tick();
      checks++; if (a_out_valid !== 4'b1000) begin errors++; $display("FAIL ar_resume_valid: got %b expected 1000", a_out_valid); end
      checks++; if (a_out_data[31:24] !== 8'h77) begin errors++; $display("FAIL ar_resume_data: got %h expected 77", a_out_data[31:24]); end
      a_in_valid = 1'b0;
      tick();
   endtask

   task automatic test_soak();
      logic [3:0] mv;
      logic [7:0] md [4];
      logic       exp_rdy;
      mv = 4'b0000;
      for (int k = 0; k < 4; k++) md[k] = 8'h00;
      for (int c = 0; c < 2000; c++) begin
         checks++; if (a_out_valid !== mv) begin errors++; $display("FAIL soak_valid@%0d: got %b expected %b", c, a_out_valid, mv); end
         for (int k = 0; k < 4; k++) begin
            if (mv[k]) begin
               checks++;
               if (a_out_data[k*8 +: 8] !== md[k]) begin
                  errors++;
                  $display("FAIL soak_data@%0d ch%0d: got %h expected %h", c, k, a_out_data[k*8 +: 8], md[k]);
               end
            end
         end
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_sel    = 2'($urandom_range(0, 3));
         a_in_data   = 8'($urandom);
         a_out_ready = 4'($urandom) | 4'($urandom);
         #1;
         exp_rdy = !mv[a_in_sel] || a_out_ready[a_in_sel];
         checks++; if (a_in_ready !== exp_rdy) begin errors++; $display("FAIL soak_in_ready@%0d: got %b expected %b", c, a_in_ready, exp_rdy); end
         for (int k = 0; k < 4; k++) begin
            if (mv[k] && a_out_ready[k]) mv[k] = 1'b0;
         end
         if (a_in_valid && exp_rdy) begin
            mv[a_in_sel] = 1'b1;
            md[a_in_sel] = a_in_data;
         end
         tick();
      end
      a_in_valid = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b1;
      a_in_valid = 1'b0;
      a_in_sel   = 2'd0;
      a_in_data  = 8'h00;
      a_out_ready = 4'h0;
      b_in_valid = 1'b0;
      b_in_sel   = 2'd0;
      b_in_data  = 8'h00;
      b_out_ready = 3'h0;
      test_reset();
      test_route();
      test_backpressure();
      test_reload();
      test_drop();
      test_async_reset();
      test_soak();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
